ahb_sram_slave: RTL and testbench



---
 rtl/ahb_sram_slave.sv | 129 ++++++++++++
 tb/tb_ahb_sram_slave.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: word-organised memory with byte/halfword writes,
// programmable wait states, a read-only low region and two-cycle ERROR responses.
module ahb_sram_slave #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned RO_WORDS    = 4
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic [1:0]  HTRANS,
  input  logic        HMASTLOCK,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_ERR1 = 3'd3;
  localparam logic [2:0] S_ERR2 = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [3:0]        lanes_q, lanes_d;
  logic              write_q, write_d;

  logic [31:0]       mem_q [(1 << ADDR_W)];

  logic              accept;
  logic              req_err;
  logic [ADDR_W-1:0] req_idx;
  logic [3:0]        req_lanes;

  // Burst type, protection, lock and the upper address bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HADDR[31:ADDR_W+2]};

  assign accept  = HSEL & HREADY & HTRANS[1];
  assign req_idx = HADDR[ADDR_W+1:2];

  always_comb begin
    req_lanes = 4'b1111;
    case (HSIZE)
      3'b000:  req_lanes = 4'b0001 << HADDR[1:0];
      3'b001:  req_lanes = HADDR[1] ? 4'b1100 : 4'b0011;
      default: req_lanes = 4'b1111;
    endcase
    req_err = (HSIZE > 3'b010)
           || (HSIZE == 3'b001 && HADDR[0])
           || (HSIZE == 3'b010 && HADDR[1:0] != 2'b00)
           || (HWRITE && (32'(req_idx) < RO_WORDS));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    lanes_d = lanes_q;
    write_d = write_q;
    case (state_q)
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_DATA;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        // IDLE, DATA and ERR2 all accept a new (possibly pipelined) address phase.
        if (accept) begin
          idx_d   = req_idx;
          lanes_d = req_lanes;
          if (req_err) begin
            state_d = S_ERR1;
            write_d = 1'b0;
          end else begin
            write_d = HWRITE;
            if (WAIT_STATES > 0) begin
              state_d = S_WAIT;
              cnt_d   = 4'(WAIT_STATES - 1);
            end else begin
              state_d = S_DATA;
            end
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      lanes_q <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lanes_q <= lanes_d;
      write_q <= write_d;
    end
  end

  // Reset forces state_q to IDLE asynchronously, so an interrupted write never commits.
  always_ff @(posedge HCLK) begin
    if (state_q == S_DATA && write_q) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (lanes_q[b]) mem_q[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  assign HREADYOUT = (state_q != S_WAIT) && (state_q != S_ERR1);
  assign HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
  assign HRDATA    = (state_q == S_DATA && !write_q) ? mem_q[idx_q] : '0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: one instance with one wait state, one with none,
// checked against a byte-addressed memory model.
module tb_ahb_sram_slave;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL1, HSEL0;
  logic [31:0] HADDR, HWDATA;
  logic        HWRITE;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HMASTLOCK;
  logic        HREADY;
  logic [31:0] rd1, rd0;
  logic        ro1, ro0, rs1, rs0;

  always #5 HCLK = ~HCLK;

  // Only one slave is ever in a data phase; an idle slave drives ready high.
  assign HREADY = ro1 & ro0;

  ahb_sram_slave #(.ADDR_W(10), .WAIT_STATES(1), .RO_WORDS(4)) u_ws1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL1), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
    .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HWDATA(HWDATA),
    .HRDATA(rd1), .HREADYOUT(ro1), .HRESP(rs1)
  );

  ahb_sram_slave #(.ADDR_W(10), .WAIT_STATES(0), .RO_WORDS(4)) u_ws0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL0), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
    .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HWDATA(HWDATA),
    .HRDATA(rd0), .HREADYOUT(ro0), .HRESP(rs0)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Byte-addressed model memory per instance (index 1 = one wait state, 0 = none).
  logic [7:0]  mb [2][4096];
  logic [31:0] bdata [4];

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] x);
    n_chk++;
    assert (o === x) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, x);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic sample(input int w, output logic [31:0] d, output logic r, output logic e);
    if (w == 1) begin d = rd1; r = ro1; e = rs1; end
    else        begin d = rd0; r = ro0; e = rs0; end
  endtask

  function automatic logic exp_err(input logic wr, input logic [2:0] sz, input logic [31:0] a);
    int unsigned nbytes;
    if (sz > 3'd2) return 1'b1;
    nbytes = 1 << sz;
    if ((a % nbytes) != 0) return 1'b1;
    if (wr && ((a / 4) % 1024) < 4) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] mread(input int w, input logic [31:0] a);
    logic [31:0] v;
    int unsigned base;
    base = (a % 4096) & ~32'd3;
    for (int i = 0; i < 4; i++) v[8*i +: 8] = mb[w][base + i];
    return v;
  endfunction

  task automatic mwrite(input int w, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int unsigned ba;
    for (int i = 0; i < (1 << sz); i++) begin
      ba = (a + i) % 4096;
      mb[w][ba] = wd[8*(ba % 4) +: 8];
    end
  endtask

  task automatic go_idle();
    HSEL1 = 1'b0; HSEL0 = 1'b0; HTRANS = 2'b00;
  endtask

  // Single NONSEQ transfer; returns during the final data-phase cycle so the
  // next call pipelines its address phase into it.
  task automatic xfer(input int w, input logic wr, input logic [2:0] sz, input logic [31:0] a,
                      input logic [31:0] wd, input string tag, output logic [31:0] rd_o);
    logic [31:0] d;
    logic        r, e;
    int          ws;
    ws = (w == 1) ? 1 : 0;
    HSEL1 = (w == 1); HSEL0 = (w == 0);
    HTRANS = 2'b10; HADDR = a; HWRITE = wr; HSIZE = sz; HBURST = 3'b000;
    step();
    go_idle();
    HWDATA = wd;
    rd_o = '0;
    if (exp_err(wr, sz, a)) begin
      sample(w, d, r, e);
      chk({tag, "_err1_rdy"}, 32'(r), 32'd0);
      chk({tag, "_err1_resp"}, 32'(e), 32'd1);
      chk({tag, "_err1_rdata"}, d, 32'd0);
      step();
      sample(w, d, r, e);
      chk({tag, "_err2_rdy"}, 32'(r), 32'd1);
      chk({tag, "_err2_resp"}, 32'(e), 32'd1);
      chk({tag, "_err2_rdata"}, d, 32'd0);
    end else begin
      for (int i = 0; i < ws; i++) begin
        sample(w, d, r, e);
        chk({tag, "_wait_rdy"}, 32'(r), 32'd0);
        chk({tag, "_wait_resp"}, 32'(e), 32'd0);
        chk({tag, "_wait_rdata"}, d, 32'd0);
        step();
      end
      sample(w, d, r, e);
      chk({tag, "_data_rdy"}, 32'(r), 32'd1);
      chk({tag, "_data_resp"}, 32'(e), 32'd0);
      if (wr) begin
        mwrite(w, sz, a, wd);
        chk({tag, "_wr_rdata"}, d, 32'd0);
      end else begin
        chk({tag, "_rd_rdata"}, d, mread(w, a));
      end
      rd_o = d;
    end
  endtask

  // INCR4 word burst on the zero-wait instance with a BUSY after the second beat.
  task automatic burst(input logic wr, input string tag);
    logic [1:0]  tr [5] = '{2'b10, 2'b11, 2'b01, 2'b11, 2'b11};
    logic [31:0] ad [5] = '{32'h200, 32'h204, 32'h208, 32'h208, 32'h20C};
    logic        pacc;
    logic [31:0] pa, pd, d;
    logic        r, e;
    int          bi;
    pacc = 1'b0; pa = '0; pd = '0; bi = 0;
    for (int c = 0; c < 6; c++) begin
      sample(0, d, r, e);
      chk({tag, "_rdy"}, 32'(r), 32'd1);
      chk({tag, "_resp"}, 32'(e), 32'd0);
      if (pacc && wr) begin
        HWDATA = pd;
        mwrite(0, 3'd2, pa, pd);
        chk({tag, "_wr_rdata"}, d, 32'd0);
      end else if (pacc) begin
        chk({tag, "_rd_rdata"}, d, mread(0, pa));
      end else begin
        chk({tag, "_nobeat_rdata"}, d, 32'd0);
      end
      if (c < 5) begin
        HSEL0 = 1'b1; HTRANS = tr[c]; HADDR = ad[c]; HWRITE = wr;
        HSIZE = 3'd2; HBURST = 3'b011;
        pacc = tr[c][1];
        if (pacc) begin
          pa = ad[c]; pd = bdata[bi]; bi++;
        end
      end else begin
        go_idle();
        pacc = 1'b0;
      end
      step();
    end
  endtask

  initial begin
    logic [31:0] d, rv, a, wd;
    logic        r, e, wr;
    logic [2:0]  sz;

    HRESETn = 1'b0;
    HSEL1 = 1'b0; HSEL0 = 1'b0; HADDR = '0; HWRITE = 1'b0; HSIZE = 3'd2;
    HBURST = '0; HPROT = 4'b0011; HTRANS = 2'b00; HMASTLOCK = 1'b0; HWDATA = '0;
    repeat (2) @(posedge HCLK);
    #3 HRESETn = 1'b1;
    step();

    for (int i = 0; i < 4; i++) begin
      sample(1, d, r, e);
      chk("idle1_rdy", 32'(r), 32'd1);
      chk("idle1_resp", 32'(e), 32'd0);
      chk("idle1_rdata", d, 32'd0);
      sample(0, d, r, e);
      chk("idle0_rdy", 32'(r), 32'd1);
      chk("idle0_rdata", d, 32'd0);
      step();
    end

    xfer(1, 1'b1, 3'd2, 32'h100, 32'hDEADBEEF, "w100", rv);
    xfer(1, 1'b0, 3'd2, 32'h100, 32'h0, "r100", rv);
    chk("r100_const", rv, 32'hDEADBEEF);

    xfer(1, 1'b1, 3'd2, 32'h100, 32'h11223344, "w100b", rv);
    xfer(1, 1'b1, 3'd0, 32'h101, 32'h00004200, "wbyte", rv);
    xfer(1, 1'b0, 3'd2, 32'h100, 32'h0, "rbyte", rv);
    chk("rbyte_const", rv, 32'h11224244);
    xfer(1, 1'b1, 3'd1, 32'h102, 32'hAAAA0000, "whalf", rv);
    xfer(1, 1'b0, 3'd2, 32'h100, 32'h0, "rhalf", rv);
    chk("rhalf_const", rv, 32'hAAAA4244);

    xfer(1, 1'b1, 3'd2, 32'h008, 32'h12345678, "err_ro", rv);
    xfer(1, 1'b1, 3'd1, 32'h101, 32'hFFFFFFFF, "err_mis", rv);
    xfer(1, 1'b1, 3'd3, 32'h100, 32'hFFFFFFFF, "err_size", rv);
    xfer(1, 1'b0, 3'd2, 32'h100, 32'h0, "r_after_err", rv);
    chk("r_after_err_const", rv, 32'hAAAA4244);

    for (int i = 0; i < 4; i++) bdata[i] = $urandom;
    burst(1'b1, "bw");
    burst(1'b0, "br");

    for (int i = 4; i < 16; i++) xfer(1, 1'b1, 3'd2, 32'(i * 4), $urandom, "init", rv);
    for (int k = 0; k < 40; k++) begin
      wr = 1'($urandom_range(0, 1));
      sz = 3'($urandom_range(0, 3));
      if (sz == 3'd3) sz = 3'($urandom_range(3, 7));
      a = 32'($urandom_range(0, 63));
      if (!wr && a < 16) a = a + 16;
      a = a | (32'($urandom_range(0, 3)) << 12);
      wd = $urandom;
      xfer(1, wr, sz, a, wd, "rand", rv);
    end

    xfer(1, 1'b1, 3'd2, 32'h300, 32'h0, "w300", rv);
    HSEL1 = 1'b1; HTRANS = 2'b10; HADDR = 32'h300; HWRITE = 1'b1; HSIZE = 3'd2;
    step();
    go_idle();
    HWDATA = 32'hCAFEF00D;
    sample(1, d, r, e);
    chk("rst_wait_rdy", 32'(r), 32'd0);
    #2 HRESETn = 1'b0;
    #1;
    sample(1, d, r, e);
    chk("rst_async_rdy", 32'(r), 32'd1);
    chk("rst_async_resp", 32'(e), 32'd0);
    chk("rst_async_rdata", d, 32'd0);
    repeat (2) @(posedge HCLK);
    #3 HRESETn = 1'b1;
    step();
    xfer(1, 1'b0, 3'd2, 32'h300, 32'h0, "r300", rv);
    chk("r300_const", rv, 32'h0);
    go_idle();
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
